// File: rtl/mask_morph3x3.sv
// mask_morph3x3: 3x3 binary erode/dilate on a streamed skin mask.
// Two line buffers feed a causal 3x3 window; video timing is delayed 2 ce-cycles.
module mask_morph3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int MODE  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       mask,
    output logic       de_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       mask_out,
    output logic [9:0] c_x,
    output logic [9:0] c_y
);

    localparam int         AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] W_LIM = 10'(IMG_W);
    localparam logic [9:0] H_LIM = 10'(IMG_H);

    logic          lb0 [IMG_W];
    logic          lb1 [IMG_W];
    logic [AW-1:0] addr;
    logic          in_range;
    logic          tap1;
    logic          tap0;
    logic          pix;
    logic          de_q;
    logic          vs_q;
    logic [2:0]    w2;
    logic [2:0]    w1;
    logic [2:0]    w0;
    logic [8:0]    win;
    logic          de1;
    logic          hs1;
    logic          vs1;
    logic          ok1;
    logic          res;

    assign addr     = c_x[AW-1:0];
    assign in_range = (c_x < W_LIM) && (c_y < H_LIM);
    assign tap1     = in_range ? lb1[addr] : 1'b0;
    assign tap0     = in_range ? lb0[addr] : 1'b0;
    assign pix      = in_range & mask;
    assign win      = {w2, w1, w0};

    always_ff @(posedge clk) begin
        if (rst) begin
            c_x  <= '0;
            c_y  <= '0;
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (ce) begin
            de_q <= de;
            vs_q <= vsync;
            if (de) begin
                if (c_x < W_LIM)
                    c_x <= c_x + 10'd1;
            end else if (de_q) begin
                c_x <= '0;
            end
            // frame start beats a simultaneous line-end increment
            if (vsync && !vs_q)
                c_y <= '0;
            else if (de_q && !de && (c_y < H_LIM))
                c_y <= c_y + 10'd1;
        end
    end

    // RAM is never cleared; stale rows only reach the border-masked region
    always_ff @(posedge clk) begin
        if (!rst && ce && de && in_range) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w2        <= '0;
            w1        <= '0;
            w0        <= '0;
            de1       <= 1'b0;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            ok1       <= 1'b0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            mask_out  <= 1'b0;
        end else if (ce) begin
            if (de) begin
                w2 <= {w2[1:0], tap1};
                w1 <= {w1[1:0], tap0};
                w0 <= {w0[1:0], pix};
            end
            de1       <= de;
            hs1       <= hsync;
            vs1       <= vsync;
            ok1       <= de && in_range &&
                         (c_x >= 10'd2) && (c_y >= 10'd2);
            de_out    <= de1;
            hsync_out <= hs1;
            vsync_out <= vs1;
            mask_out  <= res;
        end
    end

    always_comb begin
        res = 1'b0;
        unique case (1'b1)
            (MODE == 0): res = ok1 & (&win);
            (MODE != 0): res = ok1 & (|win);
        endcase
    end

endmodule

// File: tb/tb_mask_morph3x3.sv
// tb_mask_morph3x3: directed frames through erode and dilate instances.
// Expected pixels come from closed-form rules for each test image.
module tb_mask_morph3x3;

    localparam int W      = 16;
    localparam int H      = 12;
    localparam int PX     = 9;
    localparam int PY     = 5;
    localparam int HX     = 4;
    localparam int HY     = 7;
    localparam int ALL1   = 0;
    localparam int SINGLE = 1;
    localparam int HOLE   = 2;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic m0;
        logic m1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       mask;
    logic       de_o0, hs_o0, vs_o0, m_o0;
    logic       de_o1, hs_o1, vs_o1, m_o1;
    logic [9:0] cx0, cy0, cx1, cy1;
    int         ncmp = 0;
    int         nerr = 0;
    bit         tog  = 1'b0;
    exp_t       p0;
    exp_t       p1;

    always #5 clk = ~clk;

    mask_morph3x3 #(.IMG_W(W), .IMG_H(H), .MODE(0)) u_ero (
        .clk(clk), .rst(rst), .ce(ce), .de(de), .hsync(hsync),
        .vsync(vsync), .mask(mask), .de_out(de_o0),
        .hsync_out(hs_o0), .vsync_out(vs_o0), .mask_out(m_o0),
        .c_x(cx0), .c_y(cy0)
    );

    mask_morph3x3 #(.IMG_W(W), .IMG_H(H), .MODE(1)) u_dil (
        .clk(clk), .rst(rst), .ce(ce), .de(de), .hsync(hsync),
        .vsync(vsync), .mask(mask), .de_out(de_o1),
        .hsync_out(hs_o1), .vsync_out(vs_o1), .mask_out(m_o1),
        .c_x(cx1), .c_y(cy1)
    );

    task automatic chk(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic pix(input int pat, input int x, input int y);
        if (x >= W) return 1'b0;
        if (pat == SINGLE) return (x == PX) && (y == PY);
        if (pat == HOLE) return !((x == HX) && (y == HY));
        return 1'b1;
    endfunction

    function automatic logic expv(input int pat, input bit dil,
                                  input int x, input int y);
        bit blk;
        if (x < 2 || y < 2 || x >= W || y >= H) return 1'b0;
        if (pat == ALL1) return 1'b1;
        if (pat == SINGLE) begin
            blk = x >= PX && x <= PX + 2 && y >= PY && y <= PY + 2;
            return dil && blk;
        end
        blk = x >= HX && x <= HX + 2 && y >= HY && y <= HY + 2;
        return dil || !blk;
    endfunction

    task automatic step(input logic d, input logic h, input logic v,
                        input logic m, input logic e0, input logic e1);
        de    = d;
        hsync = h;
        vsync = v;
        mask  = m;
        @(posedge clk);
        #1;
        if (rst) begin
            p0 = '0;
            p1 = '0;
        end else if (ce) begin
            p1 = p0;
            p0 = '{d, h, v, e0, e1};
        end
        chk("de_out0", 10'(de_o0), 10'(p1.de));
        chk("hsync_out0", 10'(hs_o0), 10'(p1.hs));
        chk("vsync_out0", 10'(vs_o0), 10'(p1.vs));
        chk("mask_out_erode", 10'(m_o0), 10'(p1.m0));
        chk("de_out1", 10'(de_o1), 10'(p1.de));
        chk("mask_out_dilate", 10'(m_o1), 10'(p1.m1));
    endtask

    // in toggle mode every real cycle is followed by a ce=0 cycle of junk
    task automatic tick(input logic d, input logic h, input logic v,
                        input logic m, input logic e0, input logic e1);
        step(d, h, v, m, e0, e1);
        if (tog) begin
            ce = 1'b0;
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b0, 1'b0);
            ce = 1'b1;
        end
    endtask

    task automatic frame(input int pat, input int blank, input int len,
                         input int extra, input int rline);
        int yr;
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        for (int y = 0; y < H + extra; y++) begin
            yr = (rline >= 0 && y >= rline) ? y - rline : y;
            for (int x = 0; x < len; x++) begin
                chk("c_x", cx0, 10'((x < W) ? x : W));
                chk("c_y", cy0, 10'((yr < H) ? yr : H));
                tick(1, 0, 0, pix(pat, x, yr),
                     expv(pat, 1'b0, x, yr), expv(pat, 1'b1, x, yr));
            end
            for (int b = 0; b < blank; b++) begin
                rst = (y + 1 == rline) && (b == 0);
                tick(0, (b >= 1) && (b < 5), 0, 0, 0, 0);
                if (rst) begin
                    rst = 1'b0;
                    chk("c_x_after_rst", cx0, 10'd0);
                    chk("c_y_after_rst", cy0, 10'd0);
                end
            end
        end
    endtask

    initial begin
        p0    = '0;
        p1    = '0;
        rst   = 1'b1;
        ce    = 1'b1;
        de    = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        mask  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_de_out", 10'(de_o0), 10'd0);
        chk("rst_hsync_out", 10'(hs_o0), 10'd0);
        chk("rst_vsync_out", 10'(vs_o0), 10'd0);
        chk("rst_mask_out", 10'(m_o1), 10'd0);
        chk("rst_c_x", cx0, 10'd0);
        chk("rst_c_y", cy0, 10'd0);
        rst   = 1'b0;
        de    = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        mask  = 1'b0;

        frame(ALL1, 2, W, 0, -1);
        frame(ALL1, 2, W, 0, -1);
        frame(SINGLE, 16, W, 0, -1);
        frame(HOLE, 16, W, 0, -1);
        tog = 1'b1;
        frame(ALL1, 3, W, 0, -1);
        frame(HOLE, 3, W, 0, -1);
        tog = 1'b0;
        frame(ALL1, 4, W, 0, 6);
        frame(ALL1, 4, W, 0, -1);
        frame(ALL1, 4, W + 8, 2, -1);
        frame(HOLE, 4, W + 8, 0, -1);
        frame(SINGLE, 4, W, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
